// File: rtl/mac_unit_parallel_stream_if.sv
// Stream bundle between the operand buffers, the dot-product MAC and the writeback stage.
// The master modport is the producer/consumer side and the slave modport is the MAC.
interface mac_unit_parallel_stream_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int RESULT_WIDTH = 16,
    parameter int SHIFT_WIDTH  = 5
);
    logic                               in_valid;
    logic                               in_ready;
    logic                               in_first;
    logic                               in_last;
    logic                               act_signed;
    logic [VEC_LENGTH*DATA_WIDTH-1:0]   act_in;
    logic [VEC_LENGTH*DATA_WIDTH-1:0]   w_in;
    logic signed [ACC_WIDTH-1:0]        accum_prev;
    logic [SHIFT_WIDTH-1:0]             out_shift;
    logic                               out_valid;
    logic                               out_ready;
    logic signed [RESULT_WIDTH-1:0]     result;
    logic signed [ACC_WIDTH-1:0]        acc_out;
    logic                               acc_sat;

    modport master (
        output in_valid, in_first, in_last, act_signed, act_in, w_in, accum_prev, out_shift,
        output out_ready,
        input  in_ready, out_valid, result, acc_out, acc_sat
    );

    modport slave (
        input  in_valid, in_first, in_last, act_signed, act_in, w_in, accum_prev, out_shift,
        input  out_ready,
        output in_ready, out_valid, result, acc_out, acc_sat
    );
endinterface

// File: rtl/mac_unit_parallel_stream.sv
// Streaming VEC_LENGTH-lane dot-product MAC: product stage, registered adder tree,
// saturating group accumulator and a rounded, shifted, saturated result register.
module mac_unit_parallel_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int RESULT_WIDTH = 16,
    parameter int SHIFT_WIDTH  = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    mac_unit_parallel_stream_if.slave     bus
);
    localparam int LOG2   = $clog2(VEC_LENGTH);
    localparam int PROD_W = 2 * DATA_WIDTH + 1;
    localparam int SUM_W  = PROD_W + LOG2;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0]   RES_MAX = {{(ACC_WIDTH+2-RESULT_WIDTH){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0]   RES_MIN = {{(ACC_WIDTH+2-RESULT_WIDTH){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};
    localparam logic [SHIFT_WIDTH-1:0]      SHIFT_ONE = {{(SHIFT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH:0]   WIDE_ONE  = {{ACC_WIDTH{1'b0}}, 1'b1};

    function automatic logic signed [PROD_W-1:0] ext_act(input logic [DATA_WIDTH-1:0] a,
                                                         input logic sgn);
        return {{(PROD_W-DATA_WIDTH){sgn & a[DATA_WIDTH-1]}}, a};
    endfunction

    function automatic logic signed [PROD_W-1:0] ext_w(input logic [DATA_WIDTH-1:0] w);
        return {{(PROD_W-DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
    endfunction

    // Two top bits of an ACC_WIDTH+1 sum differ only when it left the accumulator range.
    function automatic logic signed [ACC_WIDTH-1:0] clamp_acc(input logic signed [ACC_WIDTH:0] v);
        if (v[ACC_WIDTH] != v[ACC_WIDTH-1]) begin
            return v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            return v[ACC_WIDTH-1:0];
        end
    endfunction

    function automatic logic signed [RESULT_WIDTH-1:0] clamp_res(input logic signed [ACC_WIDTH:0] v);
        if (v > RES_MAX) begin
            return RES_MAX[RESULT_WIDTH-1:0];
        end else if (v < RES_MIN) begin
            return RES_MIN[RESULT_WIDTH-1:0];
        end else begin
            return v[RESULT_WIDTH-1:0];
        end
    endfunction

    logic advance_s;
    logic accept_s;
    logic out_valid_r;

    assign advance_s    = !(out_valid_r && !bus.out_ready);
    assign bus.in_ready = advance_s && !reset;
    assign accept_s     = bus.in_valid && bus.in_ready;

    // ---------------- stage 1: lane products ----------------
    logic signed [PROD_W-1:0]    prod_s   [VEC_LENGTH];
    logic signed [PROD_W-1:0]    s1_prod_r[VEC_LENGTH];
    logic                        s1_valid_r;
    logic                        s1_first_r;
    logic                        s1_last_r;
    logic signed [ACC_WIDTH-1:0] s1_prev_r;
    logic [SHIFT_WIDTH-1:0]      s1_shift_r;

    // Per-lane activation x weight with the activation signedness applied.
    always_comb begin
        for (int i = 0; i < VEC_LENGTH; i++) begin
            prod_s[i] = ext_act(bus.act_in[i*DATA_WIDTH +: DATA_WIDTH], bus.act_signed)
                      * ext_w(bus.w_in[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Stage-1 register; a bubble clears only the valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_prev_r  <= '0;
            s1_shift_r <= '0;
            for (int i = 0; i < VEC_LENGTH; i++) begin
                s1_prod_r[i] <= '0;
            end
        end else if (advance_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_first_r <= bus.in_first;
                s1_last_r  <= bus.in_last;
                s1_prev_r  <= bus.accum_prev;
                s1_shift_r <= bus.out_shift;
                for (int i = 0; i < VEC_LENGTH; i++) begin
                    s1_prod_r[i] <= prod_s[i];
                end
            end
        end
    end

    // ---------------- stage 2: adder tree ----------------
    // Each level adds adjacent pairs and grows by one bit, so the final sum is exact.
    for (genvar l = 0; l <= LOG2; l++) begin : g_lvl
        logic signed [PROD_W+l-1:0] node_s [VEC_LENGTH >> l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < VEC_LENGTH; i++) begin : g_i
                assign node_s[i] = s1_prod_r[i];
            end
        end else begin : g_add
            for (genvar i = 0; i < (VEC_LENGTH >> l); i++) begin : g_i
                assign node_s[i] = {g_lvl[l-1].node_s[2*i][PROD_W+l-2],   g_lvl[l-1].node_s[2*i]}
                                 + {g_lvl[l-1].node_s[2*i+1][PROD_W+l-2], g_lvl[l-1].node_s[2*i+1]};
            end
        end
    end

    logic signed [SUM_W-1:0]     tree_sum_s;
    logic signed [SUM_W-1:0]     s2_sum_r;
    logic                        s2_valid_r;
    logic                        s2_first_r;
    logic                        s2_last_r;
    logic signed [ACC_WIDTH-1:0] s2_prev_r;
    logic [SHIFT_WIDTH-1:0]      s2_shift_r;

    assign tree_sum_s = g_lvl[LOG2].node_s[0];

    // Stage-2 register follows stage 1 whenever the pipeline advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_first_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_prev_r  <= '0;
            s2_shift_r <= '0;
            s2_sum_r   <= '0;
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            s2_first_r <= s1_first_r;
            s2_last_r  <= s1_last_r;
            s2_prev_r  <= s1_prev_r;
            s2_shift_r <= s1_shift_r;
            s2_sum_r   <= tree_sum_s;
        end
    end

    // ---------------- stage 3: accumulate and emit ----------------
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic                        sat_r;
    logic signed [ACC_WIDTH-1:0] base_s;
    logic signed [ACC_WIDTH:0]   acc_sum_s;
    logic                        ovf_s;
    logic signed [ACC_WIDTH-1:0] acc_new_s;
    logic                        sat_new_s;
    logic signed [ACC_WIDTH:0]   round_s;
    logic signed [ACC_WIDTH:0]   rounded_s;
    logic signed [ACC_WIDTH:0]   shifted_s;
    logic signed [RESULT_WIDTH-1:0] res_new_s;
    logic                        step_s;
    logic                        emit_s;

    assign step_s = advance_s && s2_valid_r;
    assign emit_s = step_s && s2_last_r;

    // Next accumulator, sticky flag and the rounded/shifted/clamped result.
    always_comb begin
        base_s    = s2_first_r ? s2_prev_r : acc_r;
        acc_sum_s = {base_s[ACC_WIDTH-1], base_s}
                  + {{(ACC_WIDTH+1-SUM_W){s2_sum_r[SUM_W-1]}}, s2_sum_r};
        ovf_s     = acc_sum_s[ACC_WIDTH] != acc_sum_s[ACC_WIDTH-1];
        acc_new_s = clamp_acc(acc_sum_s);
        sat_new_s = s2_first_r ? ovf_s : (sat_r | ovf_s);
        if (s2_shift_r != '0) begin
            round_s = WIDE_ONE << (s2_shift_r - SHIFT_ONE);
        end else begin
            round_s = '0;
        end
        rounded_s = {acc_new_s[ACC_WIDTH-1], acc_new_s} + round_s;
        shifted_s = rounded_s >>> s2_shift_r;
        res_new_s = clamp_res(shifted_s);
    end

    // Accumulator and sticky saturation flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= '0;
            sat_r <= 1'b0;
        end else if (step_s) begin
            acc_r <= acc_new_s;
            sat_r <= sat_new_s;
        end
    end

    logic signed [RESULT_WIDTH-1:0] result_r;
    logic signed [ACC_WIDTH-1:0]    acc_out_r;
    logic                           acc_sat_r;

    // Result registers; a new emit on a consume edge replaces the old result without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            result_r    <= '0;
            acc_out_r   <= '0;
            acc_sat_r   <= 1'b0;
        end else if (emit_s) begin
            out_valid_r <= 1'b1;
            result_r    <= res_new_s;
            acc_out_r   <= acc_new_s;
            acc_sat_r   <= sat_new_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.acc_out   = acc_out_r;
    assign bus.acc_sat   = acc_sat_r;
endmodule

// File: tb/tb_mac_unit_parallel_stream.sv
// Directed bench for mac_unit_parallel_stream with hand-computed expectations.
module tb_mac_unit_parallel_stream;
    localparam int DW = 8;
    localparam int VL = 16;
    localparam int AW = 32;
    localparam int RW = 16;
    localparam int SW = 5;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mac_unit_parallel_stream_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW),
                                  .RESULT_WIDTH(RW), .SHIFT_WIDTH(SW)) ifc ();

    mac_unit_parallel_stream #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .ACC_WIDTH(AW),
                               .RESULT_WIDTH(RW), .SHIFT_WIDTH(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat at a negedge and return at the negedge after it is accepted.
    task automatic send(input bit first, input bit last, input bit sgn,
                        input logic [7:0] a, input logic [7:0] w,
                        input logic signed [31:0] prev, input logic [4:0] sh);
        int n;
        ifc.in_valid   = 1'b1;
        ifc.in_first   = first;
        ifc.in_last    = last;
        ifc.act_signed = sgn;
        for (int i = 0; i < VL; i++) begin
            ifc.act_in[i*DW +: DW] = a;
            ifc.w_in[i*DW +: DW]   = w;
        end
        ifc.accum_prev = prev;
        ifc.out_shift  = sh;
        n = 0;
        while (!ifc.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", ifc.in_ready);
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int n;
        n = 0;
        while (!ifc.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = ifc.out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b want 0", ifc.in_ready); end
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", ifc.out_valid); end
        total++; if (ifc.result !== 16'sd0) begin bad++; $display("FAIL rst_result: got %0d want 0", ifc.result); end
        total++; if (ifc.acc_out !== 32'sd0) begin bad++; $display("FAIL rst_acc_out: got %0d want 0", ifc.acc_out); end
        total++; if (ifc.acc_sat !== 1'b0) begin bad++; $display("FAIL rst_acc_sat: got %0b want 0", ifc.acc_sat); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_latency();
        send(1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 32'sd0, 5'd0);
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL lat_edge1: out_valid got %0b want 0", ifc.out_valid); end
        @(negedge clk);
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL lat_edge2: out_valid got %0b want 0", ifc.out_valid); end
        @(negedge clk);
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL lat_edge3: out_valid got %0b want 1", ifc.out_valid); end
        total++; if (ifc.result !== 16'sd16) begin bad++; $display("FAIL single_result: got %0d want 16", ifc.result); end
        total++; if (ifc.acc_out !== 32'sd16) begin bad++; $display("FAIL single_acc: got %0d want 16", ifc.acc_out); end
        total++; if (ifc.acc_sat !== 1'b0) begin bad++; $display("FAIL single_sat: got %0b want 0", ifc.acc_sat); end
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        bit ok;
        send(1'b1, 1'b1, 1'b0, 8'd255, 8'h80, 32'sd0, 5'd4);
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL uns4_valid: got 0 want 1"); end
        total++; if (ifc.acc_out !== -32'sd522240) begin bad++; $display("FAIL uns4_acc: got %0d want -522240", ifc.acc_out); end
        total++; if (ifc.result !== -16'sd32640) begin bad++; $display("FAIL uns4_result: got %0d want -32640", ifc.result); end
        @(negedge clk);
        send(1'b1, 1'b1, 1'b0, 8'd255, 8'h80, 32'sd0, 5'd0);
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL uns0_valid: got 0 want 1"); end
        total++; if (ifc.result !== -16'sd32768) begin bad++; $display("FAIL uns0_result: got %0d want -32768", ifc.result); end
        @(negedge clk);
    endtask

    task automatic test_four_beat();
        int pulses;
        logic signed [31:0] seen;
        pulses = 0;
        seen   = '0;
        send(1'b1, 1'b0, 1'b1, 8'd2, 8'd3, 32'sd10, 5'd0);
        send(1'b0, 1'b0, 1'b1, 8'd2, 8'd3, 32'sd999, 5'd0);
        send(1'b0, 1'b0, 1'b1, 8'd2, 8'd3, 32'sd999, 5'd0);
        send(1'b0, 1'b1, 1'b1, 8'd2, 8'd3, 32'sd999, 5'd0);
        for (int k = 0; k < 6; k++) begin
            if (ifc.out_valid) begin
                pulses++;
                seen = ifc.acc_out;
            end
            @(negedge clk);
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL four_pulses: got %0d want 1", pulses); end
        total++; if (seen !== 32'sd394) begin bad++; $display("FAIL four_acc: got %0d want 394", seen); end
    endtask

    task automatic test_continue();
        bit ok;
        send(1'b0, 1'b1, 1'b1, 8'd1, 8'd1, 32'sd5000, 5'd0);
        wait_out(ok);
        total++; if (!ok || ifc.acc_out !== 32'sd410) begin bad++; $display("FAIL continue_acc: got %0d want 410", ifc.acc_out); end
        @(negedge clk);
    endtask

    task automatic test_rounding();
        bit ok;
        send(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 32'sd5, 5'd1);
        wait_out(ok);
        total++; if (!ok || ifc.result !== 16'sd3) begin bad++; $display("FAIL round_pos: got %0d want 3", ifc.result); end
        @(negedge clk);
        send(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, -32'sd5, 5'd1);
        wait_out(ok);
        total++; if (!ok || ifc.result !== -16'sd2) begin bad++; $display("FAIL round_neg: got %0d want -2", ifc.result); end
        total++; if (ifc.acc_out !== -32'sd5) begin bad++; $display("FAIL round_acc: got %0d want -5", ifc.acc_out); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        bit ok;
        send(1'b1, 1'b1, 1'b1, 8'd127, 8'd127, 32'sd2147483547, 5'd0);
        wait_out(ok);
        total++; if (!ok || ifc.acc_out !== 32'sd2147483647) begin bad++; $display("FAIL sat_acc: got %0d want 2147483647", ifc.acc_out); end
        total++; if (ifc.acc_sat !== 1'b1) begin bad++; $display("FAIL sat_flag: got %0b want 1", ifc.acc_sat); end
        total++; if (ifc.result !== 16'sd32767) begin bad++; $display("FAIL sat_result: got %0d want 32767", ifc.result); end
        @(negedge clk);
        send(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 32'sd0, 5'd0);
        wait_out(ok);
        total++; if (!ok || ifc.acc_sat !== 1'b0) begin bad++; $display("FAIL sat_restart: got %0b want 0", ifc.acc_sat); end
        total++; if (ifc.acc_out !== 32'sd0) begin bad++; $display("FAIL sat_restart_acc: got %0d want 0", ifc.acc_out); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cnt;
        logic signed [31:0] got [3];
        ifc.out_ready = 1'b0;
        send(1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 32'sd0, 5'd0);
        send(1'b1, 1'b1, 1'b1, 8'd2, 8'd1, 32'sd0, 5'd0);
        send(1'b1, 1'b1, 1'b1, 8'd3, 8'd1, 32'sd0, 5'd0);
        total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %0b want 0", ifc.in_ready); end
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %0b want 1", ifc.out_valid); end
        repeat (3) @(negedge clk);
        total++; if (ifc.result !== 16'sd16 || ifc.acc_out !== 32'sd16) begin bad++; $display("FAIL bp_hold: got %0d want 16", ifc.acc_out); end
        ifc.out_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (ifc.out_valid) begin
                if (cnt < 3) got[cnt] = ifc.acc_out;
                cnt++;
            end
            @(negedge clk);
        end
        total++; if (cnt != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", cnt); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (got[k] !== 32'(16 * (k + 1))) begin
                bad++; $display("FAIL bp_order%0d: got %0d want %0d", k, got[k], 16 * (k + 1));
            end
        end
    endtask

    task automatic test_reset_mid_group();
        int pulses;
        send(1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 32'sd0, 5'd0);
        send(1'b0, 1'b1, 1'b1, 8'd1, 8'd1, 32'sd0, 5'd0);
        reset = 1'b1;
        @(negedge clk);
        total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %0b want 0", ifc.in_ready); end
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (ifc.out_valid) pulses++;
            @(negedge clk);
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL mid_no_emit: got %0d want 0", pulses); end
        total++; if (ifc.acc_out !== 32'sd0) begin bad++; $display("FAIL mid_acc_clear: got %0d want 0", ifc.acc_out); end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        ifc.in_valid   = 1'b0;
        ifc.in_first   = 1'b0;
        ifc.in_last    = 1'b0;
        ifc.act_signed = 1'b1;
        ifc.act_in     = '0;
        ifc.w_in       = '0;
        ifc.accum_prev = '0;
        ifc.out_shift  = '0;
        ifc.out_ready  = 1'b1;
        test_reset();
        test_single_latency();
        test_unsigned();
        test_four_beat();
        test_continue();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_reset_mid_group();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
